// File: rtl/ahb_arbiter_if.sv
// Request/grant bundle between the AHB masters' side and the bus arbiter.
interface ahb_arbiter_if #(
    parameter int HMAS_NUM     = 5,
    parameter int HBURST_WIDTH = 3,
    parameter int MID_W        = $clog2(HMAS_NUM)
);
    logic [HMAS_NUM-1:0]     hbusreq;
    logic [HMAS_NUM-1:0]     hlock;
    logic [1:0]              htrans;
    logic [HBURST_WIDTH-1:0] hburst;
    logic                    hready;
    logic [HMAS_NUM-1:0]     hgrant;
    logic [MID_W-1:0]        hmaster;
    logic [MID_W-1:0]        hmaster_data;
    logic                    hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmaster_data, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmaster_data, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite multi-master arbiter that never splits a fixed-length burst.
// Optional bus locking is built only when AHB_ARB_LOCK_EN is defined.
module ahb_arbiter #(
    parameter  int HMAS_NUM     = 5,
    parameter  int HBURST_WIDTH = 3,
    parameter  int DEF_MASTER   = 0,
    localparam int MID_W        = $clog2(HMAS_NUM)
) (
    input  logic         hclk,
    input  logic         hreset,
    ahb_arbiter_if.slave bus
);

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [HBURST_WIDTH-1:0] HB_WRAP4  = HBURST_WIDTH'(2);
    localparam logic [HBURST_WIDTH-1:0] HB_INCR4  = HBURST_WIDTH'(3);
    localparam logic [HBURST_WIDTH-1:0] HB_WRAP8  = HBURST_WIDTH'(4);
    localparam logic [HBURST_WIDTH-1:0] HB_INCR8  = HBURST_WIDTH'(5);
    localparam logic [HBURST_WIDTH-1:0] HB_WRAP16 = HBURST_WIDTH'(6);
    localparam logic [HBURST_WIDTH-1:0] HB_INCR16 = HBURST_WIDTH'(7);

    localparam logic [MID_W-1:0]    DEF_IDX    = MID_W'(DEF_MASTER);
    localparam logic [HMAS_NUM-1:0] DEF_ONEHOT = HMAS_NUM'(1) << DEF_MASTER;

`ifdef AHB_ARB_LOCK_EN
    typedef enum logic [1:0] {ST_ARB = 2'd0, ST_BURST = 2'd1, ST_LOCKED = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_ARB = 2'd0, ST_BURST = 2'd1} state_t;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_next;
    logic [MID_W-1:0]    r_gidx;
    logic [HMAS_NUM-1:0] r_hgrant;
    logic [MID_W-1:0]    r_hmaster;
    logic [MID_W-1:0]    r_hmaster_data;

    logic                w_arb_ok;
    logic [MID_W-1:0]    w_sel;
    logic [HMAS_NUM-1:0] w_sel_onehot;
    logic [MID_W-1:0]    w_cand [HMAS_NUM];
    logic                w_fixed;
    logic [3:0]          w_len_m1;
    logic                w_burst_start;
    logic                w_acc_seq;
    logic                w_acc_end;

    // Candidate gi is the master gi+1 places after the current grantee, so the
    // grantee itself is the last one considered.
    generate
        for (genvar gi = 0; gi < HMAS_NUM; gi++) begin : g_cand
            logic [MID_W:0] w_sum;
            assign w_sum = {1'b0, r_gidx} + (MID_W + 1)'(gi + 1);
            assign w_cand[gi] = (w_sum >= (MID_W + 1)'(HMAS_NUM))
                              ? MID_W'(w_sum - (MID_W + 1)'(HMAS_NUM))
                              : w_sum[MID_W-1:0];
        end
        for (genvar gi = 0; gi < HMAS_NUM; gi++) begin : g_onehot
            assign w_sel_onehot[gi] = (w_sel == MID_W'(gi));
        end
    endgenerate

    always_comb begin
        w_sel = DEF_IDX;
        for (int i = HMAS_NUM - 1; i >= 0; i--) begin
            if (bus.hbusreq[w_cand[i]]) begin
                w_sel = w_cand[i];
            end
        end
    end

    always_comb begin
        w_fixed  = 1'b1;
        w_len_m1 = 4'd0;
        case (bus.hburst)
            HB_WRAP4,  HB_INCR4:  w_len_m1 = 4'd3;
            HB_WRAP8,  HB_INCR8:  w_len_m1 = 4'd7;
            HB_WRAP16, HB_INCR16: w_len_m1 = 4'd15;
            default:              w_fixed  = 1'b0;
        endcase
    end

    assign w_burst_start = bus.hready && (bus.htrans == TR_NONSEQ) && w_fixed;
    assign w_acc_seq     = bus.hready && (bus.htrans == TR_SEQ);
    assign w_acc_end     = bus.hready && ((bus.htrans == TR_IDLE) || (bus.htrans == TR_NONSEQ));

    // A burst's opening NONSEQ keeps the grant with its owner; the handover is
    // scheduled from the beat count so the next owner's NONSEQ follows the last SEQ.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_arb_ok     = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_burst_start) begin
                    w_cnt_next   = w_len_m1;
                    w_state_next = ST_BURST;
                end else begin
                    w_arb_ok = bus.hready;
                end
            end
            ST_BURST: begin
                if (w_burst_start) begin
                    w_cnt_next = w_len_m1;
                end else if (w_acc_end) begin
                    w_state_next = ST_ARB;
                    w_cnt_next   = 4'd0;
                    w_arb_ok     = 1'b1;
                end else if (w_acc_seq) begin
                    w_arb_ok   = (r_cnt == 4'd2);
                    w_cnt_next = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_next = ST_ARB;
                    end
                end
            end
`ifdef AHB_ARB_LOCK_EN
            ST_LOCKED: begin
                if (w_burst_start) begin
                    w_cnt_next = w_len_m1;
                end else if (w_acc_seq && (r_cnt != 4'd0)) begin
                    w_cnt_next = r_cnt - 4'd1;
                end else if (w_acc_end) begin
                    w_cnt_next = 4'd0;
                end
                if (bus.hready && !bus.hlock[r_gidx]) begin
                    w_state_next = ST_ARB;
                    w_cnt_next   = 4'd0;
                    w_arb_ok     = 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = ST_ARB;
                w_cnt_next   = 4'd0;
            end
        endcase
`ifdef AHB_ARB_LOCK_EN
        if (w_arb_ok && bus.hlock[w_sel]) begin
            w_state_next = ST_LOCKED;
        end
`endif
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state        <= ST_ARB;
            r_cnt          <= 4'd0;
            r_gidx         <= DEF_IDX;
            r_hgrant       <= DEF_ONEHOT;
            r_hmaster      <= DEF_IDX;
            r_hmaster_data <= DEF_IDX;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_arb_ok) begin
                r_gidx   <= w_sel;
                r_hgrant <= w_sel_onehot;
            end
            if (bus.hready) begin
                r_hmaster      <= r_gidx;
                r_hmaster_data <= r_hmaster;
            end
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic r_hmastlock;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_hmastlock <= 1'b0;
        end else if (bus.hready) begin
            r_hmastlock <= bus.hlock[r_gidx];
        end
    end

    assign bus.hmastlock = r_hmastlock;
`else
    logic w_unused_hlock;
    assign w_unused_hlock = ^bus.hlock;
    assign bus.hmastlock  = 1'b0;
`endif

    assign bus.hgrant       = r_hgrant;
    assign bus.hmaster      = r_hmaster;
    assign bus.hmaster_data = r_hmaster_data;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed vector table plus randomized traffic against a beat-level model.
`timescale 1ns/1ps
module tb_ahb_arbiter;
    localparam int N   = 5;
    localparam int DEF = 0;
`ifdef AHB_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SEQ = 2'd3;
    localparam int M_OPEN = 0, M_BURST = 1, M_LOCK = 2;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;
    always #5 hclk = ~hclk;

    ahb_arbiter_if #(.HMAS_NUM(N), .HBURST_WIDTH(3)) bus ();

    ahb_arbiter #(.HMAS_NUM(N), .HBURST_WIDTH(3), .DEF_MASTER(DEF)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lk;
        logic [1:0]   tr;
        logic [2:0]   bu;
        logic         rdy;
        logic [N-1:0] eg;
        int           ehm;
        int           ehmd;
        logic         eml;
    } vec_t;

    vec_t vecs[$];
    int n_pass  = 0;
    int n_total = 0;

    // Reference model: owner index, address/data owners, burst beats still owed.
    int m_g, m_hm, m_hmd, m_ml, m_mode, m_left;

    function automatic void add(input logic [N-1:0] req, input logic [N-1:0] lk,
                                input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                                input logic [N-1:0] eg, input int ehm, input int ehmd,
                                input logic eml);
        vec_t v;
        v.req = req; v.lk = lk; v.tr = tr; v.bu = bu; v.rdy = rdy;
        v.eg = eg; v.ehm = ehm; v.ehmd = ehmd; v.eml = eml;
        vecs.push_back(v);
    endfunction

    function automatic int rr_pick(input int g, input logic [N-1:0] req);
        for (int i = 1; i <= N; i++) begin
            if (req[(g + i) % N]) return (g + i) % N;
        end
        return DEF;
    endfunction

    function automatic int burst_len(input logic [2:0] bu);
        case (bu)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [N-1:0] req, input logic [N-1:0] lk,
                              input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        int sel, len, old_g, old_hm;
        bit ok;
        if (rst) begin
            m_g = DEF; m_hm = DEF; m_hmd = DEF; m_ml = 0; m_mode = M_OPEN; m_left = 0;
            return;
        end
        if (!rdy) return;
        sel    = rr_pick(m_g, req);
        len    = burst_len(bu);
        old_g  = m_g;
        old_hm = m_hm;
        ok     = 1'b0;
        if (m_mode == M_LOCK) begin
            if (!lk[m_g]) begin ok = 1'b1; m_mode = M_OPEN; end
        end else if (tr == NS && len > 0) begin
            m_mode = M_BURST;
            m_left = len - 1;
        end else if (m_mode == M_OPEN) begin
            ok = 1'b1;
        end else if (tr == IDLE || tr == NS) begin
            ok = 1'b1;
            m_mode = M_OPEN;
            m_left = 0;
        end else if (tr == SEQ) begin
            ok = (m_left == 2);
            m_left--;
            if (m_left == 0) m_mode = M_OPEN;
        end
        if (ok) begin
            m_g = sel;
            if (LOCK_EN && lk[sel]) m_mode = M_LOCK;
        end
        m_hmd = old_hm;
        m_hm  = old_g;
        m_ml  = LOCK_EN ? int'(lk[old_g]) : 0;
    endtask

    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] lk, input logic [1:0] tr,
                         input logic [2:0] bu, input logic rdy);
        bus.hbusreq = req;
        bus.hlock   = lk;
        bus.htrans  = tr;
        bus.hburst  = bu;
        bus.hready  = rdy;
    endtask

    task automatic check(input string tag, input int idx, input logic [N-1:0] eg,
                         input int ehm, input int ehmd, input logic eml);
        n_total++;
        if (bus.hgrant === eg && bus.hmaster === 3'(ehm) &&
            bus.hmaster_data === 3'(ehmd) && bus.hmastlock === eml) begin
            n_pass++;
            $display("%s[%0d] ok grant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b",
                     tag, idx, bus.hgrant, bus.hmaster, bus.hmaster_data, bus.hmastlock);
        end else begin
            $display("FAIL %s[%0d]: got grant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b, expected grant=%b hmaster=%0d hmaster_data=%0d hmastlock=%b",
                     tag, idx, bus.hgrant, bus.hmaster, bus.hmaster_data, bus.hmastlock,
                     eg, ehm, ehmd, eml);
        end
    endtask

    initial begin
        logic [N-1:0] r_req, r_lk, eg;
        logic [1:0]   r_tr;
        logic [2:0]   r_bu;
        logic         r_rdy, r_rst;

        // Idle after reset: default master keeps the bus
        for (int i = 0; i < 10; i++) add('0, '0, IDLE, 3'd0, 1'b1, 5'b00001, 0, 0, 1'b0);
        // Single transfers from masters 1 and 3 alternate
        add(5'b01010, '0, NS, 3'd0, 1'b1, 5'b00010, 0, 0, 1'b0);
        add(5'b01010, '0, NS, 3'd0, 1'b1, 5'b01000, 1, 0, 1'b0);
        add(5'b01010, '0, NS, 3'd0, 1'b1, 5'b00010, 3, 1, 1'b0);
        add(5'b01010, '0, NS, 3'd0, 1'b1, 5'b01000, 1, 3, 1'b0);
        // Master 2 INCR4 with master 4 waiting
        add(5'b00100, '0, IDLE, 3'd0, 1'b1, 5'b00100, 3, 1, 1'b0);
        add(5'b00100, '0, IDLE, 3'd0, 1'b1, 5'b00100, 2, 3, 1'b0);
        add(5'b10100, '0, NS,   3'd3, 1'b1, 5'b00100, 2, 2, 1'b0);
        add(5'b10100, '0, SEQ,  3'd3, 1'b1, 5'b00100, 2, 2, 1'b0);
        add(5'b10100, '0, SEQ,  3'd3, 1'b1, 5'b10000, 2, 2, 1'b0);
        add(5'b10100, '0, SEQ,  3'd3, 1'b1, 5'b10000, 4, 2, 1'b0);
        add(5'b10000, '0, NS,   3'd0, 1'b1, 5'b10000, 4, 4, 1'b0);
        // Same INCR4 with a 3-cycle wait state after the first SEQ
        add(5'b00100, '0, IDLE, 3'd0, 1'b1, 5'b00100, 4, 4, 1'b0);
        add(5'b00100, '0, IDLE, 3'd0, 1'b1, 5'b00100, 2, 4, 1'b0);
        add(5'b10100, '0, NS,   3'd3, 1'b1, 5'b00100, 2, 2, 1'b0);
        add(5'b10100, '0, SEQ,  3'd3, 1'b1, 5'b00100, 2, 2, 1'b0);
        for (int i = 0; i < 3; i++) add(5'b10100, '0, SEQ, 3'd3, 1'b0, 5'b00100, 2, 2, 1'b0);
        add(5'b10100, '0, SEQ,  3'd3, 1'b1, 5'b10000, 2, 2, 1'b0);
        add(5'b10100, '0, SEQ,  3'd3, 1'b1, 5'b10000, 4, 2, 1'b0);
        add(5'b10000, '0, IDLE, 3'd0, 1'b1, 5'b10000, 4, 4, 1'b0);
        // Master 1 INCR8 with two BUSY beats, terminated by IDLE after beat 5
        add(5'b00010, '0, IDLE, 3'd0, 1'b1, 5'b00010, 4, 4, 1'b0);
        add(5'b00010, '0, IDLE, 3'd0, 1'b1, 5'b00010, 1, 4, 1'b0);
        add(5'b00011, '0, NS,   3'd5, 1'b1, 5'b00010, 1, 1, 1'b0);
        add(5'b00011, '0, SEQ,  3'd5, 1'b1, 5'b00010, 1, 1, 1'b0);
        add(5'b00011, '0, BUSY, 3'd5, 1'b1, 5'b00010, 1, 1, 1'b0);
        add(5'b00011, '0, BUSY, 3'd5, 1'b1, 5'b00010, 1, 1, 1'b0);
        for (int i = 0; i < 3; i++) add(5'b00011, '0, SEQ, 3'd5, 1'b1, 5'b00010, 1, 1, 1'b0);
        add(5'b00011, '0, IDLE, 3'd5, 1'b1, 5'b00001, 1, 1, 1'b0);
        add(5'b00011, '0, IDLE, 3'd0, 1'b1, 5'b00010, 0, 1, 1'b0);
`ifdef AHB_ARB_LOCK_EN
        add(5'b00010, 5'b00010, IDLE, 3'd0, 1'b1, 5'b00010, 1, 0, 1'b1);
        for (int i = 0; i < 3; i++) add(5'b00110, 5'b00010, NS, 3'd0, 1'b1, 5'b00010, 1, 1, 1'b1);
        add(5'b00110, '0, NS, 3'd0, 1'b1, 5'b00100, 1, 1, 1'b0);
        add(5'b00110, '0, NS, 3'd0, 1'b1, 5'b00010, 2, 1, 1'b0);
`else
        add(5'b00010, 5'b00010, IDLE, 3'd0, 1'b1, 5'b00010, 1, 0, 1'b0);
        add(5'b00110, 5'b00010, NS, 3'd0, 1'b1, 5'b00100, 1, 1, 1'b0);
        add(5'b00110, 5'b00010, NS, 3'd0, 1'b1, 5'b00010, 2, 1, 1'b0);
        add(5'b00110, 5'b00010, NS, 3'd0, 1'b1, 5'b00100, 1, 2, 1'b0);
        add(5'b00110, '0, NS, 3'd0, 1'b1, 5'b00010, 2, 1, 1'b0);
        add(5'b00110, '0, NS, 3'd0, 1'b1, 5'b00100, 1, 2, 1'b0);
`endif

        drive('0, '0, IDLE, 3'd0, 1'b1);
        hreset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge hclk); #1;
            check("reset", i, 5'b00001, 0, 0, 1'b0);
        end
        hreset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].lk, vecs[i].tr, vecs[i].bu, vecs[i].rdy);
            @(posedge hclk); #1;
            check("vec", i, vecs[i].eg, vecs[i].ehm, vecs[i].ehmd, vecs[i].eml);
        end

        for (int t = 0; t < 1500; t++) begin
            r_rst = (t == 0) || ($urandom_range(0, 99) == 0);
            r_req = N'($urandom);
            r_lk  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            r_tr  = 2'($urandom_range(0, 3));
            r_bu  = 3'($urandom_range(0, 7));
            r_rdy = ($urandom_range(0, 3) != 0);
            hreset = r_rst;
            drive(r_req, r_lk, r_tr, r_bu, r_rdy);
            model_edge(r_rst, r_req, r_lk, r_tr, r_bu, r_rdy);
            @(posedge hclk); #1;
            eg = '0;
            eg[m_g] = 1'b1;
            check("rand", t, eg, m_hm, m_hmd, 1'(m_ml));
        end
        hreset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
